// File: rtl/csi2_pkg.sv
// Shared definitions for the CSI-2 receive packet layer.
// Contents: data-type codes, the parser state type, CRC-16 constants and the
// 6-bit header ECC function (Hamming code over DI + WC, 24 bits).
package csi2_pkg;

  localparam logic [5:0] DT_FRAME_START = 6'h00;
  localparam logic [5:0] DT_FRAME_END   = 6'h01;
  localparam logic [5:0] DT_RAW10       = 6'h2B;
  // Data types below this value are short packets (no payload, no footer).
  localparam logic [5:0] DT_LONG_MIN    = 6'h10;

  // Reflected CRC-16 (x^16+x^12+x^5+1), LSB-first bit order.
  localparam logic [15:0] CRC_SEED = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h8408;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_FOOTER,
    S_DRAIN
  } csi2_state_t;

  // d[7:0] = DI, d[15:8] = WC_L, d[23:16] = WC_H.
  function automatic logic [5:0] csi2_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^
           d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^
           d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^
           d[18] ^ d[20] ^ d[21] ^ d[22];
    p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^
           d[19] ^ d[20] ^ d[21] ^ d[23];
    p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^
           d[19] ^ d[20] ^ d[22] ^ d[23];
    p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^
           d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
    return p;
  endfunction

endpackage

// File: rtl/csi2_packet_decoder_crc16.sv
// Running CRC-16 over long-packet payload bytes.
// Ports:
//   clock_camera_byte / reset_camera_byte_n : byte clock, async active-low reset
//   clear    : reload the seed (held while a header is being parsed)
//   byte_en  : fold data into the CRC this cycle
//   data     : payload byte
//   crc      : current CRC register (final value once the payload has ended)
module csi2_crc16
  import csi2_pkg::*;
(
  input  logic        clock_camera_byte,
  input  logic        reset_camera_byte_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  always_ff @(posedge clock_camera_byte or negedge reset_camera_byte_n) begin
    if (!reset_camera_byte_n) begin
      crc <= CRC_SEED;
    end else if (clear) begin
      crc <= CRC_SEED;
    end else if (byte_en) begin
      crc <= crc16_byte(crc, data);
    end
  end

endmodule

// File: rtl/csi2_packet_decoder.sv
// CSI-2 receive packet layer (single lane, byte clock domain).
// Parses DI/WC/ECC headers, tracks frames from FS/FE short packets and
// forwards RAW10 long-packet payload bytes with per-packet error pulses.
// Optional feature macro: CSI2_CRC_CHECK_EN enables payload CRC-16 checking;
// without it the CRC bytes are consumed unchecked and crc_error_out is 0.
// Ports:
//   clock_camera_byte, reset_camera_byte_n : byte clock, async active-low reset
//   byte_en_in, byte_data_in  : lane bytes from the PHY, SoT sync byte removed
//   frame_valid_out           : high between accepted FS and FE
//   line_valid_out            : high while a forwarded line is in progress
//   payload_valid_out/payload_data_out : forwarded payload byte stream
//   packet_start_out          : pulse per good header
//   data_type_out, virtual_channel_out, word_count_out : last good header
//   line_count_out            : forwarded lines in this frame (saturating)
//   ecc_error_out, crc_error_out, truncated_error_out : error pulses
// Stream semantics: there is no backpressure. An input byte is consumed on
// every clock with byte_en_in=1; an output byte is valid for exactly the one
// clock where payload_valid_out=1 and the downstream must take it then.
module csi2_packet_decoder
  import csi2_pkg::*;
#(
  parameter logic [5:0]  DATA_TYPE       = DT_RAW10,
  parameter logic [1:0]  VIRTUAL_CHANNEL = 2'd0,
  parameter logic [15:0] MAX_WORD_COUNT  = 16'd4096
) (
  input  logic        clock_camera_byte,
  input  logic        reset_camera_byte_n,
  input  logic        byte_en_in,
  input  logic [7:0]  byte_data_in,
  output logic        frame_valid_out,
  output logic        line_valid_out,
  output logic        payload_valid_out,
  output logic [7:0]  payload_data_out,
  output logic        packet_start_out,
  output logic [5:0]  data_type_out,
  output logic [1:0]  virtual_channel_out,
  output logic [15:0] word_count_out,
  output logic [15:0] line_count_out,
  output logic        ecc_error_out,
  output logic        crc_error_out,
  output logic        truncated_error_out
);

  csi2_state_t state;
  logic [1:0]  hdr_cnt;
  logic [7:0]  di_q;
  logic [7:0]  wc_l_q;
  logic [7:0]  wc_h_q;
  logic [15:0] remaining;
  logic        fwd_line;   // current long packet is being forwarded
  logic        foot_cnt;   // 0: expecting CRC LSB, 1: expecting CRC MSB

  // Header fields as seen while the ECC byte is on the bus.
  logic [15:0] hdr_wc;
  logic [5:0]  hdr_dt;
  logic [1:0]  hdr_vc;
  logic        hdr_ecc_ok;
  logic        vc_match;
  logic        in_packet;

  assign hdr_wc     = {wc_h_q, wc_l_q};
  assign hdr_dt     = di_q[5:0];
  assign hdr_vc     = di_q[7:6];
  assign hdr_ecc_ok = (byte_data_in == {2'b00, csi2_ecc({wc_h_q, wc_l_q, di_q})});
  assign vc_match   = (hdr_vc == VIRTUAL_CHANNEL);
  assign in_packet  = (state == S_HEADER) || (state == S_PAYLOAD) || (state == S_FOOTER);

`ifdef CSI2_CRC_CHECK_EN
  logic [15:0] crc_value;
  logic [7:0]  crc_lo_q;

  csi2_crc16 u_crc16 (
    .clock_camera_byte   (clock_camera_byte),
    .reset_camera_byte_n (reset_camera_byte_n),
    .clear               (state == S_HEADER),
    .byte_en             ((state == S_PAYLOAD) && byte_en_in),
    .data                (byte_data_in),
    .crc                 (crc_value)
  );
`else
  assign crc_error_out = 1'b0;
`endif

  always_ff @(posedge clock_camera_byte or negedge reset_camera_byte_n) begin
    if (!reset_camera_byte_n) begin
      state               <= S_IDLE;
      hdr_cnt             <= 2'd0;
      di_q                <= 8'h00;
      wc_l_q              <= 8'h00;
      wc_h_q              <= 8'h00;
      remaining           <= 16'd0;
      fwd_line            <= 1'b0;
      foot_cnt            <= 1'b0;
      frame_valid_out     <= 1'b0;
      line_valid_out      <= 1'b0;
      payload_valid_out   <= 1'b0;
      payload_data_out    <= 8'h00;
      packet_start_out    <= 1'b0;
      data_type_out       <= 6'h00;
      virtual_channel_out <= 2'd0;
      word_count_out      <= 16'd0;
      line_count_out      <= 16'd0;
      ecc_error_out       <= 1'b0;
      truncated_error_out <= 1'b0;
`ifdef CSI2_CRC_CHECK_EN
      crc_lo_q            <= 8'h00;
      crc_error_out       <= 1'b0;
`endif
    end else begin
      packet_start_out    <= 1'b0;
      ecc_error_out       <= 1'b0;
      truncated_error_out <= 1'b0;
      payload_valid_out   <= 1'b0;
`ifdef CSI2_CRC_CHECK_EN
      crc_error_out       <= 1'b0;
`endif
      if (in_packet && !byte_en_in) begin
        // Lane dropped to LP mid-packet: abandon it, keep the frame state.
        truncated_error_out <= 1'b1;
        line_valid_out      <= 1'b0;
        state               <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (byte_en_in) begin
              di_q    <= byte_data_in;
              hdr_cnt <= 2'd1;
              state   <= S_HEADER;
            end
          end
          S_HEADER: begin
            hdr_cnt <= hdr_cnt + 2'd1;
            case (hdr_cnt)
              2'd1: wc_l_q <= byte_data_in;
              2'd2: wc_h_q <= byte_data_in;
              default: begin
                if (!hdr_ecc_ok || (hdr_wc > MAX_WORD_COUNT)) begin
                  ecc_error_out <= 1'b1;
                  state         <= S_DRAIN;
                end else begin
                  packet_start_out    <= 1'b1;
                  data_type_out       <= hdr_dt;
                  virtual_channel_out <= hdr_vc;
                  word_count_out      <= hdr_wc;
                  if (hdr_dt < DT_LONG_MIN) begin
                    if (vc_match && (hdr_dt == DT_FRAME_START)) begin
                      frame_valid_out <= 1'b1;
                      line_count_out  <= 16'd0;
                    end else if (vc_match && (hdr_dt == DT_FRAME_END)) begin
                      frame_valid_out <= 1'b0;
                    end
                    state <= S_DRAIN;
                  end else begin
                    remaining <= hdr_wc;
                    fwd_line  <= (hdr_dt == DATA_TYPE) && vc_match && frame_valid_out;
                    foot_cnt  <= 1'b0;
                    state     <= (hdr_wc == 16'd0) ? S_FOOTER : S_PAYLOAD;
                  end
                end
              end
            endcase
          end
          S_PAYLOAD: begin
            remaining <= remaining - 16'd1;
            if (fwd_line) begin
              payload_valid_out <= 1'b1;
              payload_data_out  <= byte_data_in;
              line_valid_out    <= 1'b1;
            end
            if (remaining == 16'd1) begin
              state <= S_FOOTER;
            end
          end
          S_FOOTER: begin
            if (!foot_cnt) begin
              foot_cnt <= 1'b1;
`ifdef CSI2_CRC_CHECK_EN
              crc_lo_q <= byte_data_in;
`endif
            end else begin
              line_valid_out <= 1'b0;
              if (fwd_line && (line_count_out != 16'hFFFF)) begin
                line_count_out <= line_count_out + 16'd1;
              end
`ifdef CSI2_CRC_CHECK_EN
              crc_error_out <= ({byte_data_in, crc_lo_q} != crc_value);
`endif
              state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (!byte_en_in) begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csi2_packet_decoder.sv
// Directed testbench for csi2_packet_decoder: short FS/FE packets, a full
// RAW10 line, header errors, truncation, CRC corruption, filtered packets,
// frame restart and asynchronous reset mid-packet.
`timescale 1ns/1ps
module tb_csi2_packet_decoder;

  logic        clock_camera_byte;
  logic        reset_camera_byte_n;
  logic        byte_en_in;
  logic [7:0]  byte_data_in;
  logic        frame_valid_out;
  logic        line_valid_out;
  logic        payload_valid_out;
  logic [7:0]  payload_data_out;
  logic        packet_start_out;
  logic [5:0]  data_type_out;
  logic [1:0]  virtual_channel_out;
  logic [15:0] word_count_out;
  logic [15:0] line_count_out;
  logic        ecc_error_out;
  logic        crc_error_out;
  logic        truncated_error_out;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start, n_ecc, n_crc, n_trunc, n_payload;

`ifdef CSI2_CRC_CHECK_EN
  localparam logic CRC_CHECKED = 1'b1;
`else
  localparam logic CRC_CHECKED = 1'b0;
`endif

  csi2_packet_decoder dut (
    .clock_camera_byte   (clock_camera_byte),
    .reset_camera_byte_n (reset_camera_byte_n),
    .byte_en_in          (byte_en_in),
    .byte_data_in        (byte_data_in),
    .frame_valid_out     (frame_valid_out),
    .line_valid_out      (line_valid_out),
    .payload_valid_out   (payload_valid_out),
    .payload_data_out    (payload_data_out),
    .packet_start_out    (packet_start_out),
    .data_type_out       (data_type_out),
    .virtual_channel_out (virtual_channel_out),
    .word_count_out      (word_count_out),
    .line_count_out      (line_count_out),
    .ecc_error_out       (ecc_error_out),
    .crc_error_out       (crc_error_out),
    .truncated_error_out (truncated_error_out)
  );

  // Clock / reset
  initial begin
    clock_camera_byte = 1'b0;
    forever #5 clock_camera_byte = ~clock_camera_byte;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

  // Bit-serial reference CRC (reflected 0x8408), one data bit at a time.
  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_start = 0; n_ecc = 0; n_crc = 0; n_trunc = 0; n_payload = 0;
  endtask

  // Drive one byte slot, then sample the registered result 2 ns after the
  // edge that consumed it. fwd says whether this very byte must appear on
  // the payload output one cycle after it was presented.
  task automatic drive(input logic en, input logic [7:0] d, input logic fwd);
    @(negedge clock_camera_byte);
    byte_en_in   = en;
    byte_data_in = d;
    @(posedge clock_camera_byte);
    #2;
    n_start   += int'(packet_start_out);
    n_ecc     += int'(ecc_error_out);
    n_crc     += int'(crc_error_out);
    n_trunc   += int'(truncated_error_out);
    n_payload += int'(payload_valid_out);
    check("payload_valid", {31'd0, payload_valid_out}, {31'd0, fwd});
    if (fwd) check("payload_data", {24'd0, payload_data_out}, {24'd0, d});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_header(input logic [7:0] b0, b1, b2, b3);
    drive(1'b1, b0, 1'b0);
    drive(1'b1, b1, 1'b0);
    drive(1'b1, b2, 1'b0);
    drive(1'b1, b3, 1'b0);
  endtask

  task automatic send_payload(input int n, input logic fwd, output logic [15:0] crc);
    logic [7:0] d;
    crc = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      d = i[7:0];
      drive(1'b1, d, fwd);
      crc = crc_ref(crc, d);
    end
  endtask

  // CRC LSB first; line_valid must hold through the LSB and fall with the MSB.
  task automatic send_footer(input logic [15:0] crc, input logic [7:0] flip,
                             input logic exp_lv, input logic exp_crc_err);
    logic [7:0] lo;
    lo = crc[7:0] ^ flip;
    drive(1'b1, lo, 1'b0);
    check("line_valid_crc_lo", {31'd0, line_valid_out}, {31'd0, exp_lv});
    drive(1'b1, crc[15:8], 1'b0);
    check("line_valid_fall", {31'd0, line_valid_out}, 32'd0);
    check("crc_error_at_fall", {31'd0, crc_error_out}, {31'd0, exp_crc_err});
    drive(1'b1, 8'hA5, 1'b0);
    drive(1'b1, 8'h5A, 1'b0);
    idle(2);
  endtask

  initial begin
    logic [15:0] crc;
    logic [15:0] lc_before;
    reset_camera_byte_n = 1'b0;
    byte_en_in          = 1'b0;
    byte_data_in        = 8'h00;
    clear_counts();

    // Reset state
    repeat (3) @(negedge clock_camera_byte);
    check("rst_frame_valid", {31'd0, frame_valid_out}, 32'd0);
    check("rst_line_valid", {31'd0, line_valid_out}, 32'd0);
    check("rst_payload_valid", {31'd0, payload_valid_out}, 32'd0);
    check("rst_payload_data", {24'd0, payload_data_out}, 32'd0);
    check("rst_packet_start", {31'd0, packet_start_out}, 32'd0);
    check("rst_dt", {26'd0, data_type_out}, 32'd0);
    check("rst_vc", {30'd0, virtual_channel_out}, 32'd0);
    check("rst_wc", {16'd0, word_count_out}, 32'd0);
    check("rst_line_count", {16'd0, line_count_out}, 32'd0);
    check("rst_errors", {29'd0, ecc_error_out, crc_error_out, truncated_error_out}, 32'd0);
    reset_camera_byte_n = 1'b1;
    idle(2);

    // 1: FS then FE
    clear_counts();
    send_header(8'h00, 8'h00, 8'h00, 8'h00);
    check("fs_start_pulse", {31'd0, packet_start_out}, 32'd1);
    check("fs_frame_valid", {31'd0, frame_valid_out}, 32'd1);
    check("fs_line_count", {16'd0, line_count_out}, 32'd0);
    drive(1'b1, 8'hFF, 1'b0);
    check("start_pulse_width", {31'd0, packet_start_out}, 32'd0);
    idle(2);
    send_header(8'h01, 8'h00, 8'h00, 8'h07);
    check("fe_frame_valid", {31'd0, frame_valid_out}, 32'd0);
    check("fe_dt", {26'd0, data_type_out}, 32'h01);
    idle(2);
    check("t1_starts", n_start, 2);
    check("t1_ecc_errors", n_ecc, 0);

    // 2: FS + RAW10 line, WC=1610
    clear_counts();
    send_header(8'h00, 8'h00, 8'h00, 8'h00);
    idle(2);
    send_header(8'h2B, 8'h4A, 8'h06, 8'h02);
    check("raw10_wc", {16'd0, word_count_out}, 32'd1610);
    check("raw10_dt", {26'd0, data_type_out}, 32'h2B);
    send_payload(1610, 1'b1, crc);
    send_footer(crc, 8'h00, 1'b1, 1'b0);
    check("t2_payload_count", n_payload, 1610);
    check("t2_line_count", {16'd0, line_count_out}, 32'd1);
    check("t2_starts", n_start, 2);
    check("t2_errors", n_ecc + n_crc + n_trunc, 0);

    // 3: FE, FS with bad ECC (trailer resembling FS ignored), WC too large
    clear_counts();
    send_header(8'h01, 8'h00, 8'h00, 8'h07);
    idle(2);
    send_header(8'h00, 8'h00, 8'h00, 8'h01);
    check("bad_ecc_pulse", {31'd0, ecc_error_out}, 32'd1);
    send_header(8'h00, 8'h00, 8'h00, 8'h00);
    idle(2);
    check("bad_ecc_frame_valid", {31'd0, frame_valid_out}, 32'd0);
    send_header(8'h2B, 8'h01, 8'h10, 8'h12);
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    idle(2);
    check("t3_ecc_errors", n_ecc, 2);
    check("t3_starts", n_start, 1);
    check("t3_payload", n_payload, 0);

    // 4: one good short line, then truncation after 100 payload bytes
    clear_counts();
    send_header(8'h00, 8'h00, 8'h00, 8'h00);
    idle(2);
    send_header(8'h2B, 8'h08, 8'h00, 8'h32);
    send_payload(8, 1'b1, crc);
    send_footer(crc, 8'h00, 1'b1, 1'b0);
    check("t4_line_count_1", {16'd0, line_count_out}, 32'd1);
    send_header(8'h2B, 8'h4A, 8'h06, 8'h02);
    send_payload(100, 1'b1, crc);
    drive(1'b0, 8'h00, 1'b0);
    check("trunc_pulse", {31'd0, truncated_error_out}, 32'd1);
    check("trunc_line_valid", {31'd0, line_valid_out}, 32'd0);
    check("trunc_line_count", {16'd0, line_count_out}, 32'd1);
    check("trunc_frame_valid", {31'd0, frame_valid_out}, 32'd1);
    idle(2);
    send_header(8'h01, 8'h00, 8'h00, 8'h07);
    check("t4_fe_frame_valid", {31'd0, frame_valid_out}, 32'd0);
    idle(2);
    check("t4_trunc_count", n_trunc, 1);
    check("t4_payload", n_payload, 108);

    // 5: RAW10 line with CRC LSB flipped
    clear_counts();
    send_header(8'h00, 8'h00, 8'h00, 8'h00);
    idle(2);
    send_header(8'h2B, 8'h08, 8'h00, 8'h32);
    send_payload(8, 1'b1, crc);
    send_footer(crc, 8'h01, 1'b1, CRC_CHECKED);
    check("t5_crc_count", n_crc, int'(CRC_CHECKED));
    check("t5_line_count", {16'd0, line_count_out}, 32'd1);

    // 6: DT 0x2A and VC 1 lines inside the frame are consumed only
    clear_counts();
    lc_before = line_count_out;
    send_header(8'h2A, 8'h08, 8'h00, 8'h35);
    check("dt2a_dt", {26'd0, data_type_out}, 32'h2A);
    send_payload(8, 1'b0, crc);
    send_footer(crc, 8'h00, 1'b0, 1'b0);
    send_header(8'h6B, 8'h08, 8'h00, 8'h24);
    check("vc1_vc", {30'd0, virtual_channel_out}, 32'd1);
    send_payload(8, 1'b0, crc);
    send_footer(crc, 8'h00, 1'b0, 1'b0);
    check("t6_payload", n_payload, 0);
    check("t6_line_count", {16'd0, line_count_out}, {16'd0, lc_before});
    check("t6_starts", n_start, 2);

    // 7: FS inside a frame restarts the line count
    send_header(8'h00, 8'h00, 8'h00, 8'h00);
    check("restart_frame_valid", {31'd0, frame_valid_out}, 32'd1);
    check("restart_line_count", {16'd0, line_count_out}, 32'd0);
    idle(2);

    // 8: asynchronous reset mid-packet, then a fresh FS parses
    send_header(8'h2B, 8'h08, 8'h00, 8'h32);
    send_payload(3, 1'b1, crc);
    reset_camera_byte_n = 1'b0;
    byte_en_in          = 1'b0;
    #1;
    check("arst_frame_valid", {31'd0, frame_valid_out}, 32'd0);
    check("arst_line_valid", {31'd0, line_valid_out}, 32'd0);
    check("arst_payload_valid", {31'd0, payload_valid_out}, 32'd0);
    check("arst_wc", {16'd0, word_count_out}, 32'd0);
    check("arst_dt", {26'd0, data_type_out}, 32'd0);
    @(negedge clock_camera_byte);
    reset_camera_byte_n = 1'b1;
    idle(2);
    clear_counts();
    send_header(8'h00, 8'h00, 8'h00, 8'h00);
    check("post_rst_fs_frame_valid", {31'd0, frame_valid_out}, 32'd1);
    idle(2);
    check("post_rst_starts", n_start, 1);
    check("post_rst_errors", n_ecc + n_trunc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csi2_packet_decoder.md
Name: csi2_packet_decoder

Overview:
Receive-side CSI-2 packet layer for the camera path, clocked by clock_camera_byte. It takes the single-lane, sync-aligned byte stream from the D-PHY receiver and parses packet headers (DI, WC, ECC). It decodes frame-start/frame-end short packets and RAW10 long packets. Output is frame/line valid plus a payload byte stream for the downstream byte-to-pixel converter, with per-packet error flags.

Parameters:
DATA_TYPE, 6'h2B, long-packet DT forwarded as payload (RAW10).
VIRTUAL_CHANNEL, 2'd0, only packets with this VC are acted upon.
MAX_WORD_COUNT, 16'd4096, a larger WC raises ecc_error_out and drops the packet.

Ports:
clock_camera_byte  in  1  byte clock.
reset_camera_byte_n  in  1  async active-low reset.
byte_en_in  in  1  high from the first byte after the SoT sync byte until EoT.
byte_data_in  in  8  lane byte, valid when byte_en_in=1.
frame_valid_out  out  1  high between accepted FS and FE.
line_valid_out  out  1  high while forwarding DATA_TYPE payload.
payload_valid_out  out  1  payload_data_out is valid.
payload_data_out  out  8  payload byte.
packet_start_out  out  1  1-cycle pulse on each good header.
data_type_out  out  6  DT of the last good header.
virtual_channel_out  out  2  VC of the last good header.
word_count_out  out  16  WC of the last good header.
line_count_out  out  16  lines forwarded in the current frame.
ecc_error_out  out  1  1-cycle pulse: header ECC mismatch or WC too large.
crc_error_out  out  1  1-cycle pulse: payload CRC mismatch.
truncated_error_out  out  1  1-cycle pulse: byte_en_in dropped mid-packet.

Behaviour:
- Interface: reset reset_camera_byte_n, asynchronous, active-low; clock clock_camera_byte.
- All outputs reset to 0. All outputs are registered.
- States: IDLE, HEADER, PAYLOAD, FOOTER, DRAIN.
- IDLE: on byte_en_in=1, capture byte 0 (DI) and go to HEADER with header byte counter = 1.
- HEADER: capture WC_L, WC_H, then ECC. On the ECC byte, compare against the CSI-2 6-bit ECC of the 24-bit header (ECC[7:6] must be 0).
- ECC mismatch or WC>MAX_WORD_COUNT: pulse ecc_error_out and go to DRAIN.
- Good header: pulse packet_start_out and update dt/vc/wc outputs on the cycle after the ECC byte.
- Short packet (DT<6'h10), VC matches:
  - FS (6'h00): frame_valid_out=1, line_count_out=0.
  - FE (6'h01): frame_valid_out=0.
  - Other short DTs are ignored.
  - Then go to DRAIN.
- Long packet: go to PAYLOAD with remaining = WC. If WC=0, go directly to FOOTER.
- PAYLOAD:
  - Each enabled byte decrements remaining.
  - If DT==DATA_TYPE, VC matches and frame_valid_out=1, forward the byte one cycle later: payload_valid_out=1, line_valid_out=1.
  - Otherwise consume the byte without forwarding it.
  - After the last byte, go to FOOTER.
- FOOTER: consume 2 CRC bytes (LSB first). Then:
  - line_valid_out drops on the cycle after the final CRC byte.
  - line_count_out increments if the line was forwarded.
  - Go to DRAIN.
- DRAIN: ignore trailer bytes; return to IDLE when byte_en_in=0.
- byte_en_in=0 in HEADER/PAYLOAD/FOOTER:
  - Pulse truncated_error_out and clear line_valid_out.
  - Do not increment line_count_out; frame_valid_out is unchanged.
  - Go to IDLE.
- FS while frame_valid_out=1: restart the frame (line_count_out=0).
- FE while frame_valid_out=0: no effect.
- line_count_out saturates at 16'hFFFF.
- Async reset mid-packet returns to IDLE with all outputs 0; the next packet is parsed from its DI byte.

Optional Feature:
CSI2_CRC_CHECK_EN.
- Defined: CRC-16 (poly x^16+x^12+x^5+1, reflected 0x8408, seed 0xFFFF) runs over every payload byte. In FOOTER, the received CRC is compared; a mismatch pulses crc_error_out with the final line_valid_out falling edge. Forwarded data is not retracted.
- Undefined: CRC bytes are consumed without checking, crc_error_out is tied to 0, and no CRC logic is instantiated.

Decomposition:
- Package csi2_pkg:
  - DT constants DT_FRAME_START=6'h00, DT_FRAME_END=6'h01, DT_RAW10=6'h2B, DT_LONG_MIN=6'h10.
  - State enum type.
  - Pure function csi2_ecc(24-bit) returning 6 bits.
- Sub-module csi2_crc16 (clear, byte-enable, data in, 16-bit CRC out), instantiated only under CSI2_CRC_CHECK_EN.

Test Plan:
1. FS header 00 00 00 00 -> packet_start_out pulse, frame_valid_out=1, line_count_out=0; FE 01 00 00 <ECC> -> frame_valid_out=0.
2. FS, then RAW10 long packet WC=16'd1610 with a correct ECC, payload bytes 0..1609 mod 256, correct CRC -> 1610 payload_valid_out cycles, each byte delayed exactly 1 cycle; line_count_out=1; no error pulses.
3. FS header with ECC byte 0x01 -> ecc_error_out pulse, frame_valid_out stays 0, trailer ignored until byte_en_in=0.
4. Long packet with byte_en_in dropped after 100 payload bytes -> truncated_error_out pulse, line_valid_out=0, line_count_out unchanged, next FE parsed correctly.
5. With CSI2_CRC_CHECK_EN: RAW10 line with CRC LSB flipped -> crc_error_out pulse when line_valid_out falls; without the macro, no pulse.
6. Long packet DT=6'h2A, or VC=1, inside a frame -> payload consumed, payload_valid_out stays 0, line_count_out unchanged.
